// File: rtl/sipo_frame_arbiter.sv
// Round-robin arbiter that lends one serial-in/parallel-out shifter to NUM_REQ
// serial requesters and presents each assembled word on a valid/ready port.
module sipo_frame_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    din,
  output logic [NUM_REQ-1:0]    grant,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [SRC_W-1:0]      dout_src,
  input  logic                  dout_ready
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                r_state;
  logic [SRC_W-1:0]      r_src;
  logic [SRC_W-1:0]      r_ptr;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;

  state_t                w_state_nxt;
  logic [SRC_W-1:0]      w_src_nxt;
  logic [SRC_W-1:0]      w_ptr_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [SRC_W-1:0]      w_pick;
  logic                  w_bit;

  // Descending scan so the last hit is the requester closest to the pointer.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [SRC_W-1:0]   p);
    logic [SRC_W-1:0] pick;
    int               idx;
    pick = p;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % NUM_REQ;
      if (r[idx]) pick = SRC_W'(idx);
    end
    return pick;
  endfunction

  function automatic logic [SRC_W-1:0] inc_wrap(input logic [SRC_W-1:0] s);
    if (int'(s) == NUM_REQ - 1) return '0;
    return s + 1'b1;
  endfunction

  assign w_pick = rr_pick(req, r_ptr);
  assign w_bit  = din[r_src];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_src   <= w_src_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    case (r_state)
      IDLE: begin
        w_cnt_nxt   = '0;
        w_shift_nxt = '0;
        if (|req) begin
          w_state_nxt = SHIFT;
          w_src_nxt   = w_pick;
        end
      end
      SHIFT: begin
        if (!req[r_src]) begin
          // Abort: drop the partial word and move the pointer past this source.
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
          w_ptr_nxt   = inc_wrap(r_src);
        end else begin
          w_shift_nxt = {r_shift[DATA_WIDTH-2:0], w_bit};
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = HOLD;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (dout_ready) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = inc_wrap(r_src);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign grant      = (r_state == SHIFT) ? (NUM_REQ'(1) << r_src) : '0;
  assign dout       = r_shift;
  assign dout_valid = (r_state == HOLD);
  assign dout_src   = r_src;

endmodule

// File: tb/tb_sipo_frame_arbiter.sv
// Bench for sipo_frame_arbiter: directed scenarios plus a randomized
// multi-frame run checked against a transaction-level round-robin model.
module tb_sipo_frame_arbiter;

  localparam int DW = 6;
  localparam int NR = 4;
  localparam int SW = 2;

  logic          clk;
  logic          resetn;
  logic [NR-1:0] req;
  logic [NR-1:0] din;
  logic [NR-1:0] grant;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [SW-1:0] dout_src;
  logic          dout_ready;

  int total;
  int bad;

  logic [DW-1:0] frame_word [NR];
  int            kbit [NR];

  sipo_frame_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .din       (din),
    .grant     (grant),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_src  (dout_src),
    .dout_ready(dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each requester streams frame_word MSB-first once it sees its grant.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (grant[i]) begin
        if (kbit[i] < DW) din[i] = frame_word[i][DW-1-kbit[i]];
        kbit[i]++;
      end else begin
        kbit[i] = 0;
        din[i]  = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    req        = '0;
    dout_ready = 1'b0;
    for (int i = 0; i < NR; i++) kbit[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    resetn = 1'b0;
    #1;
    total++; if (grant !== '0) begin bad++; $display("FAIL reset_grant got=%b want=0", grant); end
    total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout got=%h want=0", dout); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", dout_valid); end
    total++; if (dout_src !== '0) begin bad++; $display("FAIL reset_src got=%0d want=0", dout_src); end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();
    total++; if (grant !== '0) begin bad++; $display("FAIL reset_idle_grant got=%b want=0", grant); end
  endtask

  task automatic test_single_frame();
    int gcnt;
    int vcnt;
    logic [DW-1:0] cap_d;
    logic [SW-1:0] cap_s;
    do_reset();
    frame_word[0] = 6'b101100;
    req = 4'b0001;
    dout_ready = 1'b1;
    gcnt = 0; vcnt = 0; cap_d = '0; cap_s = '1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (grant == 4'b0001) gcnt++;
      if (grant != 4'b0001 && grant != 4'b0000) gcnt = 100;
      if (dout_valid) begin
        vcnt++;
        cap_d = dout;
        cap_s = dout_src;
        req = '0;
      end
    end
    total++; if (gcnt != DW) begin bad++; $display("FAIL single_grant_cycles got=%0d want=%0d", gcnt, DW); end
    total++; if (vcnt != 1) begin bad++; $display("FAIL single_valid_cycles got=%0d want=1", vcnt); end
    total++; if (cap_d !== 6'b101100) begin bad++; $display("FAIL single_dout got=%b want=101100", cap_d); end
    total++; if (cap_s !== 2'd0) begin bad++; $display("FAIL single_src got=%0d want=0", cap_s); end
  endtask

  task automatic run_order(input string name, input logic [NR-1:0] r, input int n,
                           input int e0, input int e1, input int e2, input int e3, input int e4);
    int exp_s [5];
    int got;
    int multi;
    int last_c;
    exp_s = '{e0, e1, e2, e3, e4};
    do_reset();
    for (int i = 0; i < NR; i++) frame_word[i] = DW'($urandom);
    req = r;
    dout_ready = 1'b1;
    got = 0; multi = 0; last_c = 0;
    for (int c = 0; c < 80 && got < n; c++) begin
      tick();
      if ($countones(grant) > 1) multi++;
      if (dout_valid) begin
        total++;
        if (dout_src !== SW'(exp_s[got])) begin
          bad++; $display("FAIL %s_src[%0d] got=%0d want=%0d", name, got, dout_src, exp_s[got]);
        end
        total++;
        if (dout !== frame_word[exp_s[got]]) begin
          bad++; $display("FAIL %s_dout[%0d] got=%h want=%h", name, got, dout, frame_word[exp_s[got]]);
        end
        if (got > 0) begin
          total++;
          if (c - last_c != DW + 2) begin
            bad++; $display("FAIL %s_period got=%0d want=%0d", name, c - last_c, DW + 2);
          end
        end
        last_c = c;
        got++;
      end
    end
    total++; if (got != n) begin bad++; $display("FAIL %s_frames got=%0d want=%0d", name, got, n); end
    total++; if (multi != 0) begin bad++; $display("FAIL %s_multihot got=%0d want=0", name, multi); end
    req = '0;
  endtask

  task automatic test_round_robin();
    run_order("rr", 4'b1111, 5, 0, 1, 2, 3, 0);
  endtask

  task automatic test_pointer_wrap();
    run_order("wrap", 4'b1001, 4, 0, 3, 0, 3, 0);
  endtask

  task automatic test_backpressure();
    int found;
    do_reset();
    for (int i = 0; i < NR; i++) frame_word[i] = DW'($urandom);
    req = 4'b0011;
    dout_ready = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      tick();
      if (dout_valid) found = 1;
    end
    total++; if (found != 1) begin bad++; $display("FAIL bp_valid_timeout got=0 want=1"); end
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (dout_valid !== 1'b1 || dout !== frame_word[0] || dout_src !== 2'd0 || grant !== '0) begin
        bad++;
        $display("FAIL bp_hold[%0d] got=v%b d%h s%0d g%b want=v1 d%h s0 g0000",
                 c, dout_valid, dout, dout_src, grant, frame_word[0]);
      end
    end
    dout_ready = 1'b1;
    tick();
    total++;
    if (dout_valid !== 1'b0 || grant !== '0) begin
      bad++; $display("FAIL bp_idle got=v%b g%b want=v0 g0000", dout_valid, grant);
    end
    tick();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL bp_next_grant got=%b want=0010", grant); end
    req = '0;
  endtask

  task automatic test_abort();
    int found;
    do_reset();
    for (int i = 0; i < NR; i++) frame_word[i] = DW'($urandom);
    frame_word[1] = 6'b111111;
    req = 4'b0110;
    dout_ready = 1'b1;
    tick();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL abort_first_grant got=%b want=0010", grant); end
    repeat (3) tick();
    req = 4'b0100;
    tick();
    total++;
    if (grant !== '0 || dout_valid !== 1'b0 || dout !== '0) begin
      bad++; $display("FAIL abort_drop got=g%b v%b d%h want=g0000 v0 d00", grant, dout_valid, dout);
    end
    tick();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL abort_next_grant got=%b want=0100", grant); end
    found = 0;
    for (int c = 0; c < 12 && found == 0; c++) begin
      tick();
      if (dout_valid) begin
        found = 1;
        total++;
        if (dout !== frame_word[2] || dout_src !== 2'd2) begin
          bad++; $display("FAIL abort_after_word got=d%h s%0d want=d%h s2", dout, dout_src, frame_word[2]);
        end
      end
    end
    total++; if (found != 1) begin bad++; $display("FAIL abort_after_timeout got=0 want=1"); end
    req = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    frame_word[2] = 6'b110101;
    req = 4'b0100;
    dout_ready = 1'b1;
    repeat (3) tick();
    #3;
    resetn = 1'b0;
    #1;
    total++; if (grant !== '0) begin bad++; $display("FAIL areset_grant got=%b want=0", grant); end
    total++; if (dout !== '0) begin bad++; $display("FAIL areset_dout got=%h want=0", dout); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b want=0", dout_valid); end
    total++; if (dout_src !== '0) begin bad++; $display("FAIL areset_src got=%0d want=0", dout_src); end
    #2;
    resetn = 1'b1;
    req = 4'b1111;
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL areset_restart got=%b want=0001", grant); end
    req = '0;
  endtask

  task automatic test_random_frames();
    int remaining [NR];
    int done [NR];
    logic [DW-1:0] words [NR][4];
    int total_frames;
    int accepted;
    int acc_src;
    int mp;
    int es;
    int multi;
    do_reset();
    total_frames = 0;
    for (int i = 0; i < NR; i++) begin
      remaining[i] = $urandom_range(1, 3);
      done[i] = 0;
      total_frames += remaining[i];
      for (int n = 0; n < 4; n++) words[i][n] = DW'($urandom);
      frame_word[i] = words[i][0];
    end
    for (int i = 0; i < NR; i++) req[i] = (remaining[i] > 0);
    accepted = 0; acc_src = -1; mp = 0; multi = 0;
    for (int c = 0; c < 3000 && accepted < total_frames; c++) begin
      tick();
      if (acc_src >= 0) begin
        remaining[acc_src]--;
        done[acc_src]++;
        if (done[acc_src] < 4) frame_word[acc_src] = words[acc_src][done[acc_src]];
        mp = (acc_src + 1) % NR;
        acc_src = -1;
      end
      for (int i = 0; i < NR; i++) req[i] = (remaining[i] > 0);
      dout_ready = ($urandom_range(0, 3) != 0);
      if ($countones(grant) > 1) multi++;
      if (dout_valid && dout_ready) begin
        es = -1;
        for (int k = 0; k < NR && es < 0; k++) begin
          if (remaining[(mp + k) % NR] > 0) es = (mp + k) % NR;
        end
        if (es < 0) es = 0;
        total++;
        if (dout_src !== SW'(es)) begin
          bad++; $display("FAIL rand_src[%0d] got=%0d want=%0d", accepted, dout_src, es);
        end
        total++;
        if (dout !== words[es][done[es]]) begin
          bad++; $display("FAIL rand_dout[%0d] got=%h want=%h", accepted, dout, words[es][done[es]]);
        end
        acc_src = es;
        accepted++;
      end
    end
    total++; if (accepted != total_frames) begin bad++; $display("FAIL rand_frames got=%0d want=%0d", accepted, total_frames); end
    total++; if (multi != 0) begin bad++; $display("FAIL rand_multihot got=%0d want=0", multi); end
    req = '0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    resetn = 1'b1;
    req = '0;
    din = '0;
    dout_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      kbit[i] = 0;
      frame_word[i] = '0;
    end
    test_reset();
    test_single_frame();
    test_round_robin();
    test_pointer_wrap();
    test_backpressure();
    test_abort();
    test_async_reset();
    for (int r = 0; r < 3; r++) test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
